// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access controller: bus widths, RAM op codes,
// MMIO addresses, FSM state and access-target encodings.
package mem_access_pkg;

   localparam int DATA_BUS      = 16;
   localparam int ADDR_BUS      = 16;
   localparam int SRAM_ADDR_BUS = 18;
   localparam int RAM_OP_BUS    = 2;

   typedef enum logic [RAM_OP_BUS-1:0] {
      RAM_OP_NOP   = 2'b00,
      RAM_OP_READ  = 2'b01,
      RAM_OP_WRITE = 2'b10
   } ram_op_e;

   localparam logic [ADDR_BUS-1:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [ADDR_BUS-1:0] UART_STAT_ADDR = 16'hBF01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      TGT_SRAM      = 2'd0,
      TGT_UART_DATA = 2'd1,
      TGT_UART_STAT = 2'd2
   } target_e;

endpackage

// File: rtl/mem_access_if.sv
// Pipeline request/response and SRAM/UART strobe bundle of mem_access.
// UART handshake signals exist only when UART_MMIO_EN is defined.
interface mem_access_if;
   import mem_access_pkg::*;

   logic [RAM_OP_BUS-1:0]    em_RAM_op;
   logic [ADDR_BUS-1:0]      em_RAM_addr;
   logic [DATA_BUS-1:0]      em_RAM_wdata;
   logic                     mem_stall;
   logic [DATA_BUS-1:0]      n_mw_RAM_data;
   logic [SRAM_ADDR_BUS-1:0] ram_addr;
   logic                     ram_ce_n;
   logic                     ram_oe_n;
   logic                     ram_we_n;
`ifdef UART_MMIO_EN
   logic                     uart_data_ready;
   logic                     uart_tbre;
   logic                     uart_tsre;
   logic                     uart_rdn;
   logic                     uart_wrn;

   modport slave (
      input  em_RAM_op, em_RAM_addr, em_RAM_wdata,
      input  uart_data_ready, uart_tbre, uart_tsre,
      output mem_stall, n_mw_RAM_data, ram_addr, ram_ce_n, ram_oe_n, ram_we_n,
      output uart_rdn, uart_wrn
   );

   modport master (
      output em_RAM_op, em_RAM_addr, em_RAM_wdata,
      output uart_data_ready, uart_tbre, uart_tsre,
      input  mem_stall, n_mw_RAM_data, ram_addr, ram_ce_n, ram_oe_n, ram_we_n,
      input  uart_rdn, uart_wrn
   );
`else
   modport slave (
      input  em_RAM_op, em_RAM_addr, em_RAM_wdata,
      output mem_stall, n_mw_RAM_data, ram_addr, ram_ce_n, ram_oe_n, ram_we_n
   );

   modport master (
      output em_RAM_op, em_RAM_addr, em_RAM_wdata,
      input  mem_stall, n_mw_RAM_data, ram_addr, ram_ce_n, ram_oe_n, ram_we_n
   );
`endif

endinterface

// File: rtl/mem_access_addr_decode.sv
// mem_addr_decode: combinational word-address to access-target select.
// UART_MMIO_EN maps the two serial-port addresses; otherwise everything is SRAM.
module mem_addr_decode
   import mem_access_pkg::*;
(
   input  logic [ADDR_BUS-1:0] addr_i,
   output target_e             tgt_o
);

`ifdef UART_MMIO_EN
   always_comb begin
      tgt_o = TGT_SRAM;
      if (addr_i == UART_DATA_ADDR) begin
         tgt_o = TGT_UART_DATA;
      end else if (addr_i == UART_STAT_ADDR) begin
         tgt_o = TGT_UART_STAT;
      end
   end
`else
   logic unused_addr;
   assign unused_addr = ^addr_i;
   assign tgt_o       = TGT_SRAM;
`endif

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store controller driving the shared async SRAM bus and
// stalling the pipeline until the access completes. Optional macro: UART_MMIO_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a request from EX_MEM; latches it when op != NOP
// ST_ACCESS | strobe low, wait counter running down to zero
// ST_DONE   | strobes high, store data still held, result valid for MEM_WB
module mem_access
   import mem_access_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                clk_50MHz,
   input  logic                rst,
   mem_access_if.slave         bus,
   inout  wire  [DATA_BUS-1:0] ram_data
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   ram_op_e             op_q, op_d;
   target_e             tgt_q, tgt_d;
   logic [ADDR_BUS-1:0] addr_q, addr_d;
   logic [DATA_BUS-1:0] wdata_q, wdata_d;
   logic [DATA_BUS-1:0] rdata_q, rdata_d;

   target_e             tgt_sel;
   logic [DATA_BUS-1:0] stat_word;
   logic                ce_n, oe_n, we_n, rdn, wrn, drv;

   mem_addr_decode u_addr_decode (
      .addr_i (bus.em_RAM_addr),
      .tgt_o  (tgt_sel)
   );

`ifdef UART_MMIO_EN
   assign stat_word = {14'b0, bus.uart_data_ready, bus.uart_tbre & bus.uart_tsre};
`else
   assign stat_word = '0;
`endif

   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= RAM_OP_NOP;
         tgt_q   <= TGT_SRAM;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         tgt_q   <= tgt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      tgt_d   = tgt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.em_RAM_op != RAM_OP_NOP) begin
               op_d    = ram_op_e'(bus.em_RAM_op);
               addr_d  = bus.em_RAM_addr;
               wdata_d = bus.em_RAM_wdata;
               tgt_d   = tgt_sel;
               // Status register needs no bus cycle: answer straight from the UART flags.
               if (tgt_sel == TGT_UART_STAT) begin
                  state_d = ST_DONE;
                  if (bus.em_RAM_op == RAM_OP_READ) begin
                     rdata_d = stat_word;
                  end
               end else begin
                  state_d = ST_ACCESS;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (op_q == RAM_OP_READ) begin
                  rdata_d = ram_data;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      ce_n = 1'b1;
      oe_n = 1'b1;
      we_n = 1'b1;
      rdn  = 1'b1;
      wrn  = 1'b1;
      drv  = 1'b0;
      if (state_q == ST_ACCESS) begin
         if (tgt_q == TGT_SRAM) begin
            ce_n = !((op_q == RAM_OP_READ) || (op_q == RAM_OP_WRITE));
            oe_n = (op_q != RAM_OP_READ);
            we_n = (op_q != RAM_OP_WRITE);
         end else if (tgt_q == TGT_UART_DATA) begin
            rdn = (op_q != RAM_OP_READ);
            wrn = (op_q != RAM_OP_WRITE);
         end
      end
      // Store data stays on the bus through DONE for one cycle of hold after the strobe rises.
      if (((state_q == ST_ACCESS) || (state_q == ST_DONE)) &&
          (op_q == RAM_OP_WRITE) && (tgt_q != TGT_UART_STAT)) begin
         drv = 1'b1;
      end
   end

   assign ram_data          = drv ? wdata_q : {DATA_BUS{1'bz}};
   assign bus.ram_ce_n      = ce_n;
   assign bus.ram_oe_n      = oe_n;
   assign bus.ram_we_n      = we_n;
   assign bus.ram_addr      = {2'b00, addr_q};
   assign bus.n_mw_RAM_data = rdata_q;
   assign bus.mem_stall     = (bus.em_RAM_op != RAM_OP_NOP) && (state_q != ST_DONE);

`ifdef UART_MMIO_EN
   assign bus.uart_rdn = rdn;
   assign bus.uart_wrn = wrn;
`else
   logic unused_uart_strb;
   assign unused_uart_strb = rdn & wrn;
`endif

endmodule
